// File: rtl/uart_frame_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_pkg
// Shared types and constants for the framed UART transmit path.
//   SOF_DEFAULT : default start-of-frame marker byte
//   state_t     : framer control states
//   phase_t     : which field of the frame is being transmitted
// ---------------------------------------------------------------------------
package uart_frame_pkg;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      P_SOF = 2'd0,
      P_LEN = 2'd1,
      P_PAY = 2'd2,
      P_CHK = 2'd3
   } phase_t;

endpackage

// File: rtl/frame_buf.sv
// ---------------------------------------------------------------------------
// frame_buf
// Single-frame payload store: DEPTH x 8 register array, synchronous write,
// asynchronous (combinational) read by index.
//   clk     : system clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write byte
//   i_raddr : read index
//   o_rdata : byte at i_raddr
// ---------------------------------------------------------------------------
module frame_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] w_mem [DEPTH];

   // One register per entry; contents need no reset because a frame only
   // ever reads indices it has already written.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [7:0] r_entry;
         always_ff @(posedge clk) begin
            if (i_we && (i_waddr == AW'(gi))) begin
               r_entry <= i_wdata;
            end
         end
         assign w_mem[gi] = r_entry;
      end
   endgenerate

   assign o_rdata = w_mem[i_raddr];

endmodule

// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
// Collects payload bytes into a one-frame buffer, then feeds uart_tx with
// SOF, LEN, payload..., CHK using its send/busy handshake.
// CHK = LEN ^ XOR(payload); SOF is not covered.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   wr_en      : payload write strobe (accepted only while in_ready)
//   din        : payload byte
//   wr_last    : marks final payload byte (commit)
//   in_ready   : buffer accepting writes
//   tx_busy    : busy from uart_tx
//   tx_data    : byte for uart_tx
//   tx_send    : one-cycle send pulse
//   frame_done : one-cycle pulse after the CHK byte completes
//   overflow   : one-cycle pulse when a frame is cut at DEPTH bytes
// ---------------------------------------------------------------------------
module uart_tx_framer
   import uart_frame_pkg::*;
#(
   parameter int         DEPTH = 16,
   parameter logic [7:0] SOF   = SOF_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] din,
   input  logic       wr_last,
   output logic       in_ready,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_send,
   output logic       frame_done,
   output logic       overflow
);

   localparam int AW = $clog2(DEPTH);

   state_t        r_state,    w_state_next;
   phase_t        r_phase,    w_phase_next;
   logic [7:0]    r_cnt,      w_cnt_next;
   logic [7:0]    r_chk,      w_chk_next;
   logic [AW-1:0] r_wr_ptr,   w_wr_ptr_next;
   logic [AW-1:0] r_rd_idx,   w_rd_idx_next;
   logic [7:0]    r_tx_data,  w_tx_data_next;
   logic          r_tx_send,  w_tx_send_next;
   logic          r_done,     w_done_next;
   logic          r_ovf,      w_ovf_next;
   logic          r_in_ready, w_in_ready_next;
   logic          w_we;
   logic [7:0]    w_rd_data;

   frame_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (din),
      .i_raddr (r_rd_idx),
      .o_rdata (w_rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= FILL;
         r_phase    <= P_SOF;
         r_cnt      <= '0;
         r_chk      <= '0;
         r_wr_ptr   <= '0;
         r_rd_idx   <= '0;
         r_tx_data  <= '0;
         r_tx_send  <= 1'b0;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_phase    <= w_phase_next;
         r_cnt      <= w_cnt_next;
         r_chk      <= w_chk_next;
         r_wr_ptr   <= w_wr_ptr_next;
         r_rd_idx   <= w_rd_idx_next;
         r_tx_data  <= w_tx_data_next;
         r_tx_send  <= w_tx_send_next;
         r_done     <= w_done_next;
         r_ovf      <= w_ovf_next;
         r_in_ready <= w_in_ready_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_phase_next   = r_phase;
      w_cnt_next     = r_cnt;
      w_chk_next     = r_chk;
      w_wr_ptr_next  = r_wr_ptr;
      w_rd_idx_next  = r_rd_idx;
      w_tx_data_next = r_tx_data;
      w_tx_send_next = 1'b0;
      w_done_next    = 1'b0;
      w_ovf_next     = 1'b0;
      w_we           = 1'b0;

      case (r_state)
         FILL: begin
            if (wr_en) begin
               w_we          = 1'b1;
               w_cnt_next    = r_cnt + 8'd1;
               w_wr_ptr_next = r_wr_ptr + AW'(1);
               w_chk_next    = r_chk ^ din;
               // Last free slot: the write is forced to terminate the frame.
               if (wr_last || (r_cnt == 8'(DEPTH - 1))) begin
                  w_state_next  = ISSUE;
                  w_phase_next  = P_SOF;
                  w_rd_idx_next = '0;
                  w_ovf_next    = !wr_last;
               end
            end
         end

         ISSUE: begin
            if (!tx_busy) begin
               case (r_phase)
                  P_SOF:   w_tx_data_next = SOF;
                  P_LEN:   w_tx_data_next = r_cnt;
                  P_PAY:   w_tx_data_next = w_rd_data;
                  default: w_tx_data_next = r_chk ^ r_cnt;
               endcase
               w_tx_send_next = 1'b1;
               w_state_next   = WAIT_HI;
            end
         end

         WAIT_HI: begin
            // uart_tx raises busy a cycle or so after send; wait to see it
            // before looking for the falling edge.
            if (tx_busy) begin
               w_state_next = WAIT_LO;
            end
         end

         default: begin // WAIT_LO
            if (!tx_busy) begin
               w_state_next = ISSUE;
               case (r_phase)
                  P_SOF: w_phase_next = P_LEN;
                  P_LEN: w_phase_next = P_PAY;
                  P_PAY: begin
                     if (8'(r_rd_idx) == (r_cnt - 8'd1)) begin
                        w_phase_next = P_CHK;
                     end else begin
                        w_rd_idx_next = r_rd_idx + AW'(1);
                     end
                  end
                  default: begin
                     w_done_next   = 1'b1;
                     w_cnt_next    = '0;
                     w_chk_next    = '0;
                     w_wr_ptr_next = '0;
                     w_rd_idx_next = '0;
                     w_phase_next  = P_SOF;
                     w_state_next  = FILL;
                  end
               endcase
            end
         end
      endcase

      w_in_ready_next = (w_state_next == FILL);
   end

   assign in_ready   = r_in_ready;
   assign tx_data    = r_tx_data;
   assign tx_send    = r_tx_send;
   assign frame_done = r_done;
   assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_tx_framer.sv
module tb_uart_tx_framer;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] din;
   logic       wr_last;
   logic       in_ready;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_send;
   logic       frame_done;
   logic       overflow;

   int n_pass  = 0;
   int n_total = 0;

   logic       hold_busy = 1'b0;
   int         busy_cnt  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];

   always #5 clk = ~clk;

   uart_tx_framer #(.DEPTH(16), .SOF(8'hA5)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .din        (din),
      .wr_last    (wr_last),
      .in_ready   (in_ready),
      .tx_busy    (tx_busy),
      .tx_data    (tx_data),
      .tx_send    (tx_send),
      .frame_done (frame_done),
      .overflow   (overflow)
   );

   // uart_tx model: busy rises one cycle after send, high for 10 cycles.
   assign tx_busy = hold_busy || (busy_cnt != 0);

   always @(posedge clk) begin
      if (tx_send) begin
         obs_q.push_back(tx_data);
         busy_cnt <= 10;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   task automatic write_byte(input logic [7:0] d, input logic last);
      @(negedge clk);
      wr_en = 1'b1; din = d; wr_last = last;
      @(negedge clk);
      wr_en = 1'b0; wr_last = 1'b0;
   endtask

   task automatic push_frame(input logic [7:0] pay[$]);
      logic [7:0] c;
      c = 8'(pay.size());
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(pay.size()));
      foreach (pay[i]) begin
         exp_q.push_back(pay[i]);
         c = c ^ pay[i];
      end
      exp_q.push_back(c);
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (frame_done) seen = 1;
      end
      n_total++;
      if (!seen) $display("FAIL %s frame_done: got none within budget, required pulse", name);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL %s in_ready at done: got %b required 1", name, in_ready);
      else n_pass++;
   endtask

   task automatic test_reset();
      n_total++; if (tx_data !== 8'h00) $display("FAIL reset tx_data: got %h required 00", tx_data); else n_pass++;
      n_total++; if (tx_send !== 1'b0) $display("FAIL reset tx_send: got %b required 0", tx_send); else n_pass++;
      n_total++; if (frame_done !== 1'b0) $display("FAIL reset frame_done: got %b required 0", frame_done); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL reset overflow: got %b required 0", overflow); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b required 1", in_ready); else n_pass++;
   endtask

   task automatic test_basic();
      logic [7:0] pay[$];
      logic [7:0] e, o;
      pay = '{8'h11, 8'h22};
      push_frame(pay);
      write_byte(8'h11, 1'b0);
      write_byte(8'h22, 1'b1);
      n_total++; if (in_ready !== 1'b0) $display("FAIL basic in_ready after commit: got %b required 0", in_ready); else n_pass++;
      wait_done("basic");
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx;
         $display("basic byte: got %h expected %h", o, e);
         n_total++; if (o !== e) $display("FAIL basic byte: got %h required %h", o, e); else n_pass++;
      end
      n_total++; if (obs_q.size() != 0) $display("FAIL basic extra bytes: got %0d required 0", obs_q.size()); else n_pass++;
   endtask

   task automatic test_single();
      logic [7:0] e, o;
      exp_q = '{8'hA5, 8'h01, 8'hA5, 8'hA4};
      write_byte(8'hA5, 1'b1);
      wait_done("single");
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx;
         $display("single byte: got %h expected %h", o, e);
         n_total++; if (o !== e) $display("FAIL single byte: got %h required %h", o, e); else n_pass++;
      end
      n_total++; if (obs_q.size() != 0) $display("FAIL single extra bytes: got %0d required 0", obs_q.size()); else n_pass++;
   endtask

   task automatic test_overflow();
      logic [7:0] pay[$];
      logic [7:0] e, o;
      for (int i = 0; i < 16; i++) pay.push_back(8'(8'h30 + i * 7));
      push_frame(pay);
      for (int i = 0; i < 15; i++) write_byte(pay[i], 1'b0);
      n_total++; if (overflow !== 1'b0) $display("FAIL overflow early: got %b required 0", overflow); else n_pass++;
      write_byte(pay[15], 1'b0);
      n_total++; if (overflow !== 1'b1) $display("FAIL overflow pulse: got %b required 1", overflow); else n_pass++;
      write_byte(8'hEE, 1'b0);
      n_total++; if (overflow !== 1'b0) $display("FAIL overflow width: got %b required 0", overflow); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL overflow in_ready: got %b required 0", in_ready); else n_pass++;
      wait_done("overflow");
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx;
         $display("overflow byte: got %h expected %h", o, e);
         n_total++; if (o !== e) $display("FAIL overflow byte: got %h required %h", o, e); else n_pass++;
      end
      n_total++; if (obs_q.size() != 0) $display("FAIL overflow extra bytes: got %0d required 0", obs_q.size()); else n_pass++;
   endtask

   task automatic test_busy_hold();
      logic [7:0] e, o;
      bit early = 0;
      exp_q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
      hold_busy = 1'b1;
      write_byte(8'h5A, 1'b1);
      for (int i = 0; i < 50; i++) begin
         if (tx_send) early = 1;
         @(negedge clk);
      end
      n_total++; if (early) $display("FAIL busyhold send while busy: got 1 required 0"); else n_pass++;
      hold_busy = 1'b0;
      @(negedge clk);
      n_total++; if (tx_send !== 1'b1) $display("FAIL busyhold send after release: got %b required 1", tx_send); else n_pass++;
      n_total++; if (tx_data !== 8'hA5) $display("FAIL busyhold first data: got %h required a5", tx_data); else n_pass++;
      @(negedge clk);
      n_total++; if (tx_send !== 1'b0) $display("FAIL busyhold send width: got %b required 0", tx_send); else n_pass++;
      wait_done("busyhold");
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx;
         $display("busyhold byte: got %h expected %h", o, e);
         n_total++; if (o !== e) $display("FAIL busyhold byte: got %h required %h", o, e); else n_pass++;
      end
   endtask

   task automatic test_writes_during_tx();
      logic [7:0] e, o;
      exp_q = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'hA5, 8'h01, 8'h77, 8'h76};
      write_byte(8'h01, 1'b1);
      write_byte(8'hEE, 1'b0);
      write_byte(8'hDD, 1'b1);
      write_byte(8'hCC, 1'b0);
      wait_done("txwrites1");
      write_byte(8'h77, 1'b1);
      wait_done("txwrites2");
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx;
         $display("txwrites byte: got %h expected %h", o, e);
         n_total++; if (o !== e) $display("FAIL txwrites byte: got %h required %h", o, e); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] e, o;
      bit reached = 0;
      write_byte(8'h10, 1'b0);
      write_byte(8'h20, 1'b0);
      write_byte(8'h30, 1'b1);
      for (int i = 0; i < 500 && !reached; i++) begin
         @(negedge clk);
         if (obs_q.size() >= 3) reached = 1;
      end
      n_total++; if (!reached) $display("FAIL rstmid payload phase: got %0d bytes required 3", obs_q.size()); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if (tx_send !== 1'b0) $display("FAIL rstmid tx_send: got %b required 0", tx_send); else n_pass++;
      n_total++; if (tx_data !== 8'h00) $display("FAIL rstmid tx_data: got %h required 00", tx_data); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid in_ready: got %b required 1", in_ready); else n_pass++;
      n_total++; if (frame_done !== 1'b0 || overflow !== 1'b0) $display("FAIL rstmid pulses: got %b%b required 00", frame_done, overflow); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 50 && tx_busy; i++) @(negedge clk);
      obs_q.delete();
      exp_q = '{8'hA5, 8'h01, 8'h00, 8'h01};
      write_byte(8'h00, 1'b1);
      wait_done("rstmid");
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx;
         $display("rstmid byte: got %h expected %h", o, e);
         n_total++; if (o !== e) $display("FAIL rstmid byte: got %h required %h", o, e); else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; din = 8'h00; wr_last = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_single();
      test_overflow();
      test_busy_hold();
      test_writes_during_tx();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Framed transmit path for the UART AI system: collects result bytes from the AI controller into a single-frame buffer, then drives the existing `uart_tx` byte by byte as `SOF, LEN, payload..., CHK` through its `send`/`busy` handshake. It is the sending-end counterpart of the `uart_rx` → `fifo` receive path and sits between `ai_controller` and `uart_tx`. The PC-side parser resynchronises on `SOF` and validates frames with `CHK`.

## Interface
- `DEPTH`, 16: payload buffer size in bytes, 2..255; max frame payload.
- `SOF`, 8'hA5: start-of-frame byte.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous and active-low (asserted when 0). Single clock domain.
- `wr_en` in 1: payload byte write strobe.
- `din` in 8: payload byte.
- `wr_last` in 1: qualifies `wr_en`; marks the final byte of the frame (commit).
- `in_ready` out 1: buffer accepting writes.
- `tx_busy` in 1: `busy` from `uart_tx`.
- `tx_data` out 8: byte to `uart_tx` `data_in`.
- `tx_send` out 1: one-cycle send pulse to `uart_tx`.
- `frame_done` out 1: one-cycle pulse after the `CHK` byte finishes.
- `overflow` out 1: one-cycle pulse when a frame is auto-terminated at `DEPTH`.

## Operation
- States: `FILL`, `ISSUE`, `WAIT_HI`, `WAIT_LO`.
- Field phase counter: `P_SOF`, `P_LEN`, `P_PAY`, `P_CHK`. Separate payload read index.
- `FILL`:
  - `in_ready` = 1.
  - Each `wr_en` stores `din` at `wr_ptr`, increments `cnt`, and folds `din` into `chk`, where `chk` is the XOR accumulator.
  - `wr_en && wr_last` commits the frame: next state `ISSUE`, phase `P_SOF`.
- Overflow: a write with `cnt == DEPTH-1` and `wr_last = 0` is stored and treated as last; `overflow` pulses the next cycle. In `FILL`, `cnt` can never reach `DEPTH`.
- Writes while `in_ready = 0` are ignored: no store, no `chk` change.
- `ISSUE`:
  - If `tx_busy = 0`: register `tx_data` for the current phase, assert `tx_send` for 1 cycle, go to `WAIT_HI`.
  - Otherwise hold in `ISSUE`.
- Bytes sent per phase:
  - `P_SOF`: `SOF`.
  - `P_LEN`: `cnt`.
  - `P_PAY`: `buf[rd_idx]`.
  - `P_CHK`: `chk ^ cnt`.
- `WAIT_HI`: wait for `tx_busy = 1`, then go to `WAIT_LO`.
- `WAIT_LO`: wait for `tx_busy = 0`, then advance the phase:
  - `P_PAY` repeats until `rd_idx == cnt-1`.
  - After `P_CHK`: pulse `frame_done`, clear `cnt`, `chk`, `wr_ptr` and `rd_idx`, return to `FILL`.
- `CHK` = XOR of `LEN` and all payload bytes. `SOF` is excluded.
- `LEN` is 8 bits, range 1..DEPTH. A zero-length frame is impossible, because commit needs a write.
- Simultaneous `wr_en` with any non-`FILL` state is dropped. `tx_busy` changes are only sampled in the states above.

## Timing
- Reset values:
  - `tx_data` = 0, `tx_send` = 0, `frame_done` = 0, `overflow` = 0.
  - `in_ready` = 1, state `FILL`.
  - Counters and `chk` = 0.
- All outputs are registered.
- Commit write at edge N:
  - `in_ready` = 0 from N+1.
  - First `tx_send` (`SOF`) at N+1 if `tx_busy` was 0 at N; otherwise it waits.
- `tx_send` is exactly 1 cycle wide. `tx_data` is valid from the `tx_send` cycle and stable until the next `tx_send`.
- Minimum gap between consecutive `tx_send` pulses = `busy` duration + 2 cycles.
- `frame_done` pulses in the cycle after `tx_busy` falls following `CHK`. `in_ready` = 1 in that same cycle.
- Reset asserted mid-frame: all state clears asynchronously and the partial frame is discarded. `uart_tx` completes any byte already started.

## Structure
- Package `uart_frame_pkg`:
  - `SOF_DEFAULT` (8'hA5).
  - State enum `{FILL, ISSUE, WAIT_HI, WAIT_LO}`.
  - Phase enum `{P_SOF, P_LEN, P_PAY, P_CHK}`.
- One sub-module, `frame_buf`: DEPTH×8 register array with synchronous write and asynchronous read by index.
- FSM, counters and checksum live in `uart_tx_framer`.

## Test plan
Bench `busy` model: `tx_busy` rises 1 cycle after `tx_send` and stays high 10 cycles.
- Payload `0x11`, `0x22`(last) → bytes `A5, 02, 11, 22, 31`; then `frame_done` = 1, `in_ready` = 1.
- Single byte `0xA5`(last) → `A5, 01, A5, A4`.
- DEPTH=16, 17 writes with no `wr_last` →
  - `overflow` pulses after the 16th write; the 17th is ignored.
  - `LEN` = `0x10`; `CHK` = XOR of `0x10` and bytes 1..16.
- `tx_busy` held high at commit for 50 cycles → no `tx_send` until 1 cycle after `busy` drops.
- Writes issued during transmission → not in the frame, `CHK` unaffected; the next frame contains only bytes written after `frame_done`.
- `rst` = 0 during the payload phase → outputs at reset values immediately. A following 1-byte frame `0x00` → `A5, 01, 00, 01`.
